// File: rtl/i2s_master_pkg.sv
// Shared constants and helpers for the I2S master: sample and counter widths,
// and which counter bits produce the SCK/BCK/LCK clocks.
package i2s_master_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 8;

  // Counter bit that directly becomes each generated clock
  localparam int SCK_BIT = 0;
  localparam int BCK_BIT = 2;
  localparam int LCK_BIT = 7;

  // Slot index sits between the BCK phase bits and the half-frame bit
  localparam int SLOT_LSB = BCK_BIT + 1;
  localparam int SLOT_W   = LCK_BIT - SLOT_LSB;
  localparam int NUM_SLOTS = 1 << SLOT_W;

  // Tap numbering used by the clock generator's output register
  localparam int TAP_SCK  = 0;
  localparam int TAP_BCK  = 1;
  localparam int TAP_LCK  = 2;
  localparam int NUM_TAPS = 3;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [SLOT_W-1:0]   slot_t;

  function automatic int tap_pos(input int tap);
    case (tap)
      TAP_SCK: return SCK_BIT;
      TAP_BCK: return BCK_BIT;
      default: return LCK_BIT;
    endcase
  endfunction

  // True when a counter value is the first cycle of a bit slot (BCK falling)
  function automatic logic is_slot_start(input cnt_t c);
    return (c[BCK_BIT:0] == '0);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter plus registered SCK/BCK/LCK derived from it.
// Each clock register is loaded from the next count so it tracks cnt exactly.
module i2s_clkgen
  import i2s_master_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output cnt_t cnt,
  output cnt_t cnt_next,
  output logic sck,
  output logic bck,
  output logic lck
);

  cnt_t                cnt_reg;
  logic [NUM_TAPS-1:0] tap_reg;
  logic [NUM_TAPS-1:0] tap_next;

  assign cnt_next = cnt_reg + cnt_t'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      assign tap_next[gi] = cnt_next[tap_pos(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tap_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      tap_reg <= tap_next;
    end
  end

  assign cnt = cnt_reg;
  assign sck = tap_reg[TAP_SCK];
  assign bck = tap_reg[TAP_BCK];
  assign lck = tap_reg[TAP_LCK];

endmodule

// File: rtl/i2s_master.sv
// Mono I2S master: captures one sample per 256-cycle frame and serializes it
// MSB first on both channels with the standard one-bit I2S delay.
module i2s_master
  import i2s_master_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] smp,
  output logic                sck,
  output logic                bck,
  output logic                din,
  output logic                lck,
  output logic                sampled
);

  cnt_t    cnt;
  cnt_t    cnt_next;
  sample_t smp_q_reg;
  sample_t prev_q_reg;
  logic    din_reg;
  logic    sampled_reg;

  i2s_clkgen u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .sck      (sck),
    .bck      (bck),
    .lck      (lck)
  );

  logic    frame_end;
  logic    slot_start_next;
  logic    half_next;
  slot_t   slot_next;
  sample_t word_next;
  sample_t prev_next;
  logic [NUM_SLOTS-1:0] left_bits;
  logic [NUM_SLOTS-1:0] right_bits;
  logic    din_next;

  assign frame_end       = (cnt == '1);
  assign slot_start_next = is_slot_start(cnt_next);
  assign half_next       = cnt_next[LCK_BIT];
  assign slot_next       = cnt_next[SLOT_LSB +: SLOT_W];

  // Word contents as they will be after this edge, so slot 0 of the new
  // frame already sees the freshly shifted prev word.
  assign word_next = frame_end ? smp       : smp_q_reg;
  assign prev_next = frame_end ? smp_q_reg : prev_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        // One-bit delay: slot 0 carries the LSB of the preceding word
        assign left_bits[gi]  = prev_next[0];
        assign right_bits[gi] = word_next[0];
      end else begin : g_rest
        assign left_bits[gi]  = word_next[SAMPLE_W-gi];
        assign right_bits[gi] = word_next[SAMPLE_W-gi];
      end
    end
  endgenerate

  always_comb begin
    din_next = 1'b0;
    if (half_next) begin
      din_next = right_bits[slot_next];
    end else begin
      din_next = left_bits[slot_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_q_reg   <= '0;
      prev_q_reg  <= '0;
      din_reg     <= 1'b0;
      sampled_reg <= 1'b0;
    end else begin
      if (frame_end) begin
        smp_q_reg  <= smp;
        prev_q_reg <= smp_q_reg;
      end
      // DIN only moves on BCK falling edges
      if (slot_start_next) begin
        din_reg <= din_next;
      end
      sampled_reg <= frame_end;
    end
  end

  assign din     = din_reg;
  assign sampled = sampled_reg;

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master: frame vectors from a table, plus reset,
// reset-versus-capture and free-running clock ratio sequences.
module tb_i2s_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] smp = 16'h0000;
  logic        sck, bck, din, lck, sampled;
  logic [7:0]  mcnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] smp;
    logic [31:0] frame;
  } vec_t;

  vec_t tbl [10];

  i2s_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .smp     (smp),
    .sck     (sck),
    .bck     (bck),
    .din     (din),
    .lck     (lck),
    .sampled (sampled)
  );

  always #5 clk = ~clk;

  // Reference frame counter
  always @(posedge clk) begin
    if (!rst_n) mcnt <= 8'd0;
    else        mcnt <= mcnt + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Present x before the capture edge, then collect the 32 bits sent in the
  // following frame on BCK rising edges while disturbing smp mid-frame.
  task automatic run_frame(input logic [15:0] x, output logic [31:0] got,
                           output int pulses, output int bad);
    int   guard;
    logic prev_din;
    guard = 0;
    while (mcnt != 8'd255 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("frame_sync", {24'h0, mcnt}, 32'd255);
    smp = x;
    got = '0;
    pulses = 0;
    bad = 0;
    prev_din = din;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (mcnt[2:0] == 3'd4) got[31 - int'(mcnt[7:3])] = din;
      if (mcnt == 8'd100) smp = ~x;
      if (mcnt == 8'd200) smp = x ^ 16'h5A5A;
      if (sampled) begin
        pulses++;
        if (mcnt != 8'd0 || lck) bad++;
      end
      if (din !== prev_din && mcnt[2:0] != 3'd0) bad++;
      prev_din = din;
    end
  endtask

  initial begin
    logic [31:0] got;
    int pulses, bad, total_pulses, n, din_seen, guard;
    int sck_rise, bck_rise, lck_rise, sck_hi, bck_hi, lck_hi, model_err, phase_err;
    logic p_sck, p_bck, p_lck;

    // {smp, expected {left slots 0..15, right slots 0..15}}
    tbl[0] = '{16'hA5C3, 32'h52E1D2E1};
    tbl[1] = '{16'hA5C3, 32'hD2E1D2E1};
    tbl[2] = '{16'h8001, 32'hC000C000};
    tbl[3] = '{16'h0000, 32'h80000000};
    tbl[4] = '{16'hFFFF, 32'h7FFFFFFF};
    tbl[5] = '{16'h1234, 32'h891A091A};
    tbl[6] = '{16'h0001, 32'h00008000};
    tbl[7] = '{16'h8000, 32'hC0004000};
    tbl[8] = '{16'h0000, 32'h00000000};
    tbl[9] = '{16'h5555, 32'h2AAAAAAA};

    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_state", {27'h0, sck, bck, lck, din, sampled}, 32'h0);
    rst_n = 1'b1;

    total_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].smp, got, pulses, bad);
      check($sformatf("frame%0d_smp_%h", i, tbl[i].smp), got, tbl[i].frame);
      check("sampled_pulses", 32'(pulses), 32'd1);
      check("frame_timing", 32'(bad), 32'd0);
      total_pulses += pulses;
    end
    check("pulses_10_frames", 32'(total_pulses), 32'd10);

    // Mid-frame reset while the right channel is sending a 1
    guard = 0;
    while (mcnt != 8'd130 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("midframe_din_before_reset", {31'h0, din}, 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midframe_reset_outputs", {27'h0, sck, bck, lck, din, sampled}, 32'h0);
    end
    rst_n = 1'b1;
    n = 0;
    din_seen = 0;
    while (!sampled && n < 400) begin
      @(negedge clk);
      n++;
      if (din) din_seen++;
    end
    check("first_sampled_after_release", 32'(n), 32'd256);
    check("din_zero_after_reset", 32'(din_seen), 32'd0);

    // Reset asserted on the capture edge must discard the capture
    guard = 0;
    while (mcnt != 8'd255 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    smp = 16'hFFFF;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_vs_capture", {27'h0, sck, bck, lck, din, sampled}, 32'h0);
    rst_n = 1'b1;
    din_seen = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (din) din_seen++;
    end
    check("reset_vs_capture_din", 32'(din_seen), 32'd0);

    // Free run: clock periods, duty and phase alignment
    sck_rise = 0; bck_rise = 0; lck_rise = 0;
    sck_hi = 0; bck_hi = 0; lck_hi = 0;
    model_err = 0; phase_err = 0;
    p_sck = sck; p_bck = bck; p_lck = lck;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (sck && !p_sck) sck_rise++;
      if (bck && !p_bck) bck_rise++;
      if (lck && !p_lck) lck_rise++;
      if (sck) sck_hi++;
      if (bck) bck_hi++;
      if (lck) lck_hi++;
      if ({sck, bck, lck} !== {mcnt[0], mcnt[2], mcnt[7]}) model_err++;
      if (lck !== p_lck && (bck || sck)) phase_err++;
      p_sck = sck; p_bck = bck; p_lck = lck;
    end
    check("sck_rises", 32'(sck_rise), 32'd1024);
    check("bck_rises", 32'(bck_rise), 32'd256);
    check("lck_rises", 32'(lck_rise), 32'd8);
    check("sck_high", 32'(sck_hi), 32'd1024);
    check("bck_high", 32'(bck_hi), 32'd1024);
    check("lck_high", 32'(lck_hi), 32'd1024);
    check("clock_vs_counter", 32'(model_err), 32'd0);
    check("bck_lck_phase", 32'(phase_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_master.md
I2S_MASTER -- requirements
Module: i2s_master

Interface
REQ-001 The block SHALL have no parameters; all clock ratios and the 16-bit sample width are fixed.
REQ-002 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-003 CLK  input  1  system clock, 12 MHz; all logic on its rising edge.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 SMP  input  16  signed two's-complement mono sample; sampled only at frame start.
REQ-006 SCK  output  1  master clock to DAC, CLK/2 (6 MHz).
REQ-007 BCK  output  1  bit clock, CLK/8 (1.5 MHz).
REQ-008 DIN  output  1  serial data, I2S format, MSB first.
REQ-009 LCK  output  1  word select, CLK/256 (46.875 kHz); 0 = left, 1 = right.
REQ-010 SAMPLED  output  1  one-CLK pulse marking that SMP was captured.

Function
REQ-011 Free-running 8-bit counter cnt SHALL increment by 1 every CLK cycle and wrap from 255 to 0.
REQ-012 Clock outputs SHALL be registered, glitch-free and 50% duty:
- SCK = cnt[0]
- BCK = cnt[2]
- LCK = cnt[7]
REQ-013 Slot index SHALL be cnt[6:3] (0..15) within each half-frame; half = cnt[7].
REQ-014 On the rising edge where cnt==255, the block SHALL capture SMP into smp_q and copy the old smp_q into prev_q.
REQ-015 SAMPLED SHALL be 1 exactly while cnt==0 following a capture, and 0 otherwise; one pulse per 256 cycles.
REQ-016 The same word smp_q SHALL be transmitted on both channels (mono duplicated to left and right).
REQ-017 DIN (I2S one-bit delay) SHALL be:
- left slot 0 = prev_q[0]
- left slot k (1..15) = smp_q[16-k]
- right slot 0 = smp_q[0]
- right slot k (1..15) = smp_q[16-k]
REQ-018 DIN SHALL be registered and SHALL change only coincident with BCK falling edges (cnt[2:0]==0), so it is stable around each BCK rising edge.
REQ-019 SMP changes at any time other than the cnt==255 edge SHALL have no effect on the current frame.
REQ-020 Simultaneous reset and capture edge: reset SHALL win.

Reset
REQ-021 While RST_N==0 at a CLK edge, the block SHALL load: cnt=0, smp_q=0, prev_q=0, SCK=0, BCK=0, LCK=0, DIN=0, SAMPLED=0.
REQ-022 After reset release, counting SHALL resume from 0.
REQ-023 After reset release, the first capture SHALL occur at the 256th edge, with the SAMPLED pulse in the following cycle.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no partial-word completion.

Structure
REQ-025 A shared package SHALL hold:
- constants SAMPLE_W=16, CNT_W=8
- bit positions of SCK (0), BCK (2) and LCK (7)
REQ-026 The counter/clock generator SHALL be a natural sub-module, i2s_clkgen (cnt plus registered SCK/BCK/LCK).
REQ-027 The top level SHALL hold the capture registers and the DIN serializer.

Verification
REQ-028 Reset: RST_N low for 5 cycles mid-frame -> all outputs 0 on the next edge; first SAMPLED pulse 256 cycles after release.
REQ-029 Ratios: free run for 2048 cycles -> SCK period 2, BCK period 8, LCK period 256, all 50% duty; BCK phase-locked to LCK edges.
REQ-030 Data: SMP=16'hA5C3 held, DIN sampled on BCK rising edges ->
- left slots 1..15 = A5C3 bits 15..1
- right slot 0 = 1
- right slots 1..15 = A5C3 bits 15..1
REQ-031 Frame boundary: SMP=16'h8001, then 16'h0000 at the next capture -> left slot 0 of the second frame = 1 (old bit 0); all other bits of the second frame = 0.
REQ-032 Late change: SMP toggled at cnt=100 and cnt=200 -> current frame's DIN unchanged; only the value present at cnt==255 is transmitted next.
REQ-033 SAMPLED: count pulses over 10 frames -> exactly 10 pulses, each 1 cycle wide, each with cnt==0 and LCK==0.
